uart_word_rx: RTL and testbench

- Receive-side companion to the core's word-serialising UART transmitter.
- Deserialises 8N1 bytes from `rxd` and assembles every four bytes, LSB-first, into one 32-bit word.
- Queues the words in a show-ahead FIFO that the core drains with a valid/ack handshake.
- Sits between the board's UART RX pin and the core's input port; the core uses it for program loading and data input.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_byte.sv | 101 ++++++++++
 rtl/uart_word_rx.sv | 106 ++++++++++
 tb/tb_uart_word_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the word-oriented RX/TX pair.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int WORD_BYTES     = 4;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rxd synchroniser, start/data/stop FSM and bit timer.
// UART_WORD_RX_FERR_EN enables stop-bit checking and frame_err reporting.
module uart_rx_byte import uart_pkg::*; #(
  parameter int CLK_PER_HALF_BIT = 260
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(2*CLK_PER_HALF_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] HALF_END = TW'(CLK_PER_HALF_BIT-1);
  localparam logic [TW-1:0] BIT_END  = TW'(2*CLK_PER_HALF_BIT-1);

  rx_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          sync1_q, rxd_s_q;
`ifdef UART_WORD_RX_FERR_EN
  logic          arm_q, arm_d;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
`ifdef UART_WORD_RX_FERR_EN
    arm_d      = arm_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
`ifdef UART_WORD_RX_FERR_EN
        // after a bad stop bit the line must go idle before a new start counts
        if (!arm_q) arm_d = rxd_s_q;
        else if (!rxd_s_q) state_d = START;
`else
        if (!rxd_s_q) state_d = START;
`endif
      end
      START: if (timer_q == HALF_END) begin
        timer_d   = '0;
        bit_cnt_d = '0;
        state_d   = rxd_s_q ? IDLE : DATA;
      end
      DATA: if (timer_q == BIT_END) begin
        timer_d   = '0;
        shreg_d   = {rxd_s_q, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BW'(UART_DATA_BITS-1)) state_d = STOP;
      end
      STOP: if (timer_q == BIT_END) begin
        timer_d = '0;
        state_d = IDLE;
`ifdef UART_WORD_RX_FERR_EN
        if (rxd_s_q) byte_valid = 1'b1;
        else begin
          frame_err = 1'b1;
          arm_d     = 1'b0;
        end
`else
        byte_valid = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata = shreg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rxd_s_q   <= 1'b1;
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
`ifdef UART_WORD_RX_FERR_EN
      arm_q     <= 1'b1;
`endif
    end else begin
      sync1_q   <= rxd;
      rxd_s_q   <= sync1_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
`ifdef UART_WORD_RX_FERR_EN
      arm_q     <= arm_d;
`endif
    end
  end
endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: packs 4 LSB-first bytes into 32-bit words, show-ahead FIFO.
// UART_WORD_RX_FERR_EN enables framing-error detection (ferr); otherwise ferr is 0.
module uart_word_rx import uart_pkg::*; #(
  parameter int CLK_PER_HALF_BIT = 260,
  parameter int FIFO_DEPTH_LOG2  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [31:0] core_data,
  output logic        core_data_valid,
  input  logic        core_data_ack,
  output logic        fifo_full,
  output logic        overrun,
  output logic        ferr
);
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int CW     = FIFO_DEPTH_LOG2 + 1;
  localparam int WORD_W = UART_DATA_BITS * WORD_BYTES;
  localparam int PART_W = WORD_W - UART_DATA_BITS;
  localparam int IW     = $clog2(WORD_BYTES);

  logic [7:0] rdata;
  logic       byte_valid, frame_err;

  uart_rx_byte #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx_byte (
    .clk(clk), .rst(rst), .rxd(rxd),
    .rdata(rdata), .byte_valid(byte_valid), .frame_err(frame_err)
  );

  logic [IW-1:0]              idx_q, idx_d;
  logic [PART_W-1:0]          word_q, word_d;
  logic                       push_q, push_d;
  logic [WORD_W-1:0]          push_data_q, push_data_d;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       overrun_q, overrun_d, ferr_q, ferr_d;
  logic [WORD_W-1:0]          mem_q [DEPTH];
  logic                       full, empty, do_push, do_pop;

  always_comb begin
    idx_d       = idx_q;
    word_d      = word_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (byte_valid) begin
      if (idx_q == IW'(WORD_BYTES-1)) begin
        push_d      = 1'b1;
        push_data_d = {rdata, word_q};
        idx_d       = '0;
      end else begin
        for (int k = 0; k < WORD_BYTES-1; k++)
          if (idx_q == IW'(k)) word_d[k*UART_DATA_BITS +: UART_DATA_BITS] = rdata;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // a pop in the same cycle frees the slot, so a push at full still lands
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = core_data_ack && !empty;
  assign do_push = push_q && (!full || do_pop);

  always_comb begin
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + CW'(do_push) - CW'(do_pop);
    overrun_d = overrun_q | (push_q && full && !do_pop);
    ferr_d    = ferr_q | frame_err;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      word_q      <= word_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  assign core_data       = empty ? '0 : mem_q[rd_ptr_q];
  assign core_data_valid = !empty;
  assign fifo_full       = full;
  assign overrun         = overrun_q;
  assign ferr            = ferr_q;
endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: half-bit = 4 clocks, 4-word FIFO.
module tb_uart_word_rx;
  localparam int HALF = 4;
  localparam int BIT  = 2*HALF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        core_data_ack = 1'b0;
  logic [31:0] core_data;
  logic        core_data_valid, fifo_full, overrun, ferr;
  int          checks = 0;
  int          errors = 0;

  uart_word_rx #(.CLK_PER_HALF_BIT(HALF), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .core_data(core_data), .core_data_valid(core_data_valid),
    .core_data_ack(core_data_ack), .fifo_full(fifo_full),
    .overrun(overrun), .ferr(ferr)
  );

  always #5 clk = ~clk;

  // Start bit and 8 data bits; returns 1 time unit after the stop-bit slot begins.
  task automatic send_head(input logic [7:0] b);
    @(posedge clk); #1 rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge clk);
      #1 rxd = b[i];
    end
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    send_head(b);
    rxd = stop_bit;
    repeat (BIT) @(posedge clk);
    #1 rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    repeat (3) @(posedge clk);
  endtask

  task automatic pop_word();
    @(posedge clk); #1 core_data_ack = 1'b1;
    @(posedge clk); #1 core_data_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rxd = 1'b1; core_data_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (core_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", core_data_valid); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", fifo_full); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", ferr); end
    checks++; if (core_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", core_data); end
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic();
    send_word(32'h12345678);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (core_data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", core_data_valid); end
    checks++; if (core_data !== 32'h12345678) begin errors++; $display("FAIL basic_data got %h exp 12345678", core_data); end
    pop_word();
    @(negedge clk);
    checks++; if (core_data_valid !== 1'b0) begin errors++; $display("FAIL basic_after_pop got %b exp 0", core_data_valid); end
  endtask

  task automatic test_reset_mid_word();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1; rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    send_word(32'hDEADBEEF);
    @(negedge clk);
    checks++; if (core_data_valid !== 1'b1 || core_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rstmid_data got v=%b %h exp v=1 deadbeef", core_data_valid, core_data); end
    pop_word();
    @(negedge clk);
    checks++; if (core_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_only_one got %b exp 0", core_data_valid); end
  endtask

  task automatic test_glitch();
    send_byte(8'hA1); send_byte(8'hB2);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (HALF-1) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (core_data_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_word got %b exp 0", core_data_valid); end
    send_byte(8'hC3); send_byte(8'hD4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (core_data !== 32'hD4C3B2A1) begin errors++; $display("FAIL glitch_word got %h exp d4c3b2a1", core_data); end
    pop_word();
  endtask

  task automatic test_overrun();
    logic [31:0] w [5];
    w[0] = 32'h01020304; w[1] = 32'hA5A55A5A; w[2] = 32'hFFFF0000;
    w[3] = 32'h0BADF00D; w[4] = 32'h77777777;
    do_reset();
    for (int i = 0; i < 4; i++) send_word(w[i]);
    @(negedge clk);
    checks++; if (fifo_full !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_full4 got full=%b ovr=%b exp 1 0", fifo_full, overrun); end
    send_word(w[4]);
    @(negedge clk);
    checks++; if (overrun !== 1'b1 || fifo_full !== 1'b1) begin
      errors++; $display("FAIL ovr_set got ovr=%b full=%b exp 1 1", overrun, fifo_full); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (core_data_valid !== 1'b1 || core_data !== w[i]) begin
        errors++; $display("FAIL ovr_drain%0d got v=%b %h exp v=1 %h", i, core_data_valid, core_data, w[i]); end
      pop_word();
    end
    @(negedge clk);
    checks++; if (core_data_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_empty got v=%b ovr=%b exp 0 1", core_data_valid, overrun); end
  endtask

  task automatic test_full_concurrent();
    logic [31:0] w [5];
    w[0] = 32'h10203040; w[1] = 32'h50607080; w[2] = 32'h90A0B0C0;
    w[3] = 32'hD0E0F001; w[4] = 32'hCAFEF00D;
    do_reset();
    for (int i = 0; i < 4; i++) send_word(w[i]);
    for (int i = 0; i < 3; i++) send_byte(w[4][8*i +: 8]);
    send_head(w[4][31:24]);
    rxd = 1'b1;
    // ack rises so its first pop coincides with the 5th word's push
    repeat (7) @(posedge clk);
    #1 core_data_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (core_data_valid !== 1'b1 || core_data !== w[i]) begin
        errors++; $display("FAIL conc_read%0d got v=%b %h exp v=1 %h", i, core_data_valid, core_data, w[i]); end
      if (i == 1) begin
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL conc_still_full got %b exp 1", fifo_full); end
      end
    end
    @(posedge clk); #1 core_data_ack = 1'b0;
    @(negedge clk);
    checks++; if (core_data_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL conc_end got v=%b ovr=%b exp 0 0", core_data_valid, overrun); end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'h55, 1'b0);
    repeat (20) @(posedge clk);
    send_word(32'h87654321);
    @(negedge clk);
`ifdef UART_WORD_RX_FERR_EN
    checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", ferr); end
    checks++; if (core_data !== 32'h87654321) begin errors++; $display("FAIL ferr_word got %h exp 87654321", core_data); end
`else
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL ferr_flag got %b exp 0", ferr); end
    checks++; if (core_data !== 32'h65432155) begin errors++; $display("FAIL ferr_word got %h exp 65432155", core_data); end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_word();
    test_glitch();
    test_overrun();
    test_full_concurrent();
    test_frame_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
